// File: rtl/l1_port_hakemi_pkg.sv
// l1_port_hakemi_pkg: shared constants, FSM state type and sizing helper for
// the L1 data-cache port arbiter.
package l1_port_hakemi_pkg;

    // Default bus widths of the L1 data port.
    localparam int ADRES_BIT_VARSAYILAN = 32;
    localparam int VERI_BIT_VARSAYILAN  = 32;
    localparam int VERI_BYTE_VARSAYILAN = VERI_BIT_VARSAYILAN / 8;

    // Single-bit logic levels.
    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    // Arbiter phases: idle/arbitrate, request to L1, response from L1.
    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        ISTEK = 2'd1,
        YANIT = 2'd2
    } durum_e;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int indeks_genisligi(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hakem_oncelik_secici.sv
// hakem_oncelik_secici: combinational winner picker for the L1 port arbiter.
// Default build: round-robin search starting at isaretci_i, wrapping N-1 -> 0.
// With L1_HAKEM_SABIT_ONCELIK_EN defined: fixed priority, lowest index wins and
// the pointer input is ignored.
module hakem_oncelik_secici
    import l1_port_hakemi_pkg::*;
#(
    parameter int ISTEKCI_SAYISI = 2,
    parameter int IW             = indeks_genisligi(ISTEKCI_SAYISI)
) (
    input  logic [ISTEKCI_SAYISI-1:0] istek_i,
    input  logic [IW-1:0]             isaretci_i,
    output logic [IW-1:0]             kazanan_o,
    output logic                      herhangi_o
);

    localparam int N = ISTEKCI_SAYISI;

    assign herhangi_o = |istek_i;

`ifdef L1_HAKEM_SABIT_ONCELIK_EN
    // The pointer has no meaning under fixed priority.
    logic unused_isaretci_s;
    assign unused_isaretci_s = ^isaretci_i;

    // Lowest set index wins; scanning downward lets the lowest overwrite last.
    always_comb begin
        kazanan_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            kazanan_o = istek_i[i] ? IW'(i) : kazanan_o;
        end
    end
`else
    logic [IW-1:0] ust_aday_s;
    logic [IW-1:0] alt_aday_s;
    logic          ust_var_s;

    // Round-robin: lowest requester at or above the pointer, else lowest overall (wrap).
    always_comb begin
        ust_aday_s = '0;
        alt_aday_s = '0;
        ust_var_s  = LOW;
        for (int i = N - 1; i >= 0; i--) begin
            alt_aday_s = istek_i[i] ? IW'(i) : alt_aday_s;
            ust_aday_s = (istek_i[i] && (IW'(i) >= isaretci_i)) ? IW'(i) : ust_aday_s;
            ust_var_s  = ust_var_s | (istek_i[i] && (IW'(i) >= isaretci_i));
        end
        kazanan_o = ust_var_s ? ust_aday_s : alt_aday_s;
    end
`endif

endmodule

// File: rtl/l1_port_hakemi.sv
// l1_port_hakemi: arbitrates ISTEKCI_SAYISI requesters onto one L1 data-cache
// port. A grant is held for the whole transaction (request handshake, plus the
// response handshake for reads); the response is routed to the owner only.
// Optional macro L1_HAKEM_SABIT_ONCELIK_EN selects fixed priority instead of
// round-robin and removes the round-robin pointer.
module l1_port_hakemi
    import l1_port_hakemi_pkg::*;
#(
    parameter int ISTEKCI_SAYISI = 2,
    parameter int ADRES_BIT      = ADRES_BIT_VARSAYILAN,
    parameter int VERI_BIT       = VERI_BIT_VARSAYILAN,
    parameter int VERI_BYTE      = VERI_BIT / 8
) (
    input  logic                                clk_i,
    input  logic                                rst_i,

    input  logic [ISTEKCI_SAYISI-1:0]           ist_gecerli_i,
    input  logic [ISTEKCI_SAYISI-1:0]           ist_yaz_i,
    input  logic [ISTEKCI_SAYISI*ADRES_BIT-1:0] ist_adres_i,
    input  logic [ISTEKCI_SAYISI*VERI_BIT-1:0]  ist_veri_i,
    input  logic [ISTEKCI_SAYISI*VERI_BYTE-1:0] ist_maske_i,
    output logic [ISTEKCI_SAYISI-1:0]           ist_hazir_o,

    output logic [VERI_BIT-1:0]                 yanit_veri_o,
    output logic [ISTEKCI_SAYISI-1:0]           yanit_gecerli_o,
    input  logic [ISTEKCI_SAYISI-1:0]           yanit_hazir_i,

    output logic                                port_istek_gecerli_o,
    output logic                                port_istek_yaz_o,
    output logic [ADRES_BIT-1:0]                port_istek_adres_o,
    output logic [VERI_BIT-1:0]                 port_istek_veri_o,
    output logic [VERI_BYTE-1:0]                port_istek_maske_o,
    input  logic                                port_istek_hazir_i,

    input  logic [VERI_BIT-1:0]                 port_veri_i,
    input  logic                                port_veri_gecerli_i,
    output logic                                port_veri_hazir_o
);

    localparam int N  = ISTEKCI_SAYISI;
    localparam int IW = indeks_genisligi(ISTEKCI_SAYISI);

    durum_e          durum_q;
    logic [IW-1:0]   sahip_q;
    logic [IW-1:0]   isaretci_s;
    logic [IW-1:0]   kazanan_s;
    logic            herhangi_s;

    // Fields of the current owner, selected from the flattened request buses.
    logic                 sahip_gecerli_s;
    logic                 sahip_yaz_s;
    logic [ADRES_BIT-1:0] sahip_adres_s;
    logic [VERI_BIT-1:0]  sahip_veri_s;
    logic [VERI_BYTE-1:0] sahip_maske_s;
    logic                 sahip_yanit_hazir_s;

    logic            istek_el_sikisma_s;
    logic            yanit_el_sikisma_s;

    hakem_oncelik_secici #(
        .ISTEKCI_SAYISI (ISTEKCI_SAYISI),
        .IW             (IW)
    ) u_secici (
        .istek_i    (ist_gecerli_i),
        .isaretci_i (isaretci_s),
        .kazanan_o  (kazanan_s),
        .herhangi_o (herhangi_s)
    );

`ifdef L1_HAKEM_SABIT_ONCELIK_EN
    assign isaretci_s = '0;
`else
    logic [IW-1:0] rr_isaretci_q;
    logic [IW-1:0] sonraki_isaretci_s;
    logic          tamamlandi_s;

    assign isaretci_s         = rr_isaretci_q;
    assign sonraki_isaretci_s = (sahip_q == IW'(N - 1)) ? '0 : (sahip_q + IW'(1));
    // A transaction ends on a write accept or on a read response handshake.
    assign tamamlandi_s       = (istek_el_sikisma_s & sahip_yaz_s) | yanit_el_sikisma_s;

    // Round-robin pointer moves just past the owner when its transaction ends.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_isaretci_q <= '0;
        end else if (tamamlandi_s) begin
            rr_isaretci_q <= sonraki_isaretci_s;
        end else begin
            rr_isaretci_q <= rr_isaretci_q;
        end
    end
`endif

    // AND-OR mux of the owner's request fields and response-ready bit.
    always_comb begin
        sahip_gecerli_s     = LOW;
        sahip_yaz_s         = LOW;
        sahip_adres_s       = '0;
        sahip_veri_s        = '0;
        sahip_maske_s       = '0;
        sahip_yanit_hazir_s = LOW;
        for (int i = 0; i < N; i++) begin
            sahip_gecerli_s     = sahip_gecerli_s |
                                  ((sahip_q == IW'(i)) & ist_gecerli_i[i]);
            sahip_yaz_s         = sahip_yaz_s |
                                  ((sahip_q == IW'(i)) & ist_yaz_i[i]);
            sahip_adres_s       = sahip_adres_s |
                                  ({ADRES_BIT{sahip_q == IW'(i)}} & ist_adres_i[i*ADRES_BIT +: ADRES_BIT]);
            sahip_veri_s        = sahip_veri_s |
                                  ({VERI_BIT{sahip_q == IW'(i)}} & ist_veri_i[i*VERI_BIT +: VERI_BIT]);
            sahip_maske_s       = sahip_maske_s |
                                  ({VERI_BYTE{sahip_q == IW'(i)}} & ist_maske_i[i*VERI_BYTE +: VERI_BYTE]);
            sahip_yanit_hazir_s = sahip_yanit_hazir_s |
                                  ((sahip_q == IW'(i)) & yanit_hazir_i[i]);
        end
    end

    assign istek_el_sikisma_s = (durum_q == ISTEK) & sahip_gecerli_s & port_istek_hazir_i;
    assign yanit_el_sikisma_s = (durum_q == YANIT) & port_veri_gecerli_i & sahip_yanit_hazir_s;

    // Transaction FSM: arbitrate for one cycle, then hold the grant to completion.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q <= BOSTA;
            sahip_q <= '0;
        end else begin
            case (durum_q)
                BOSTA: begin
                    if (herhangi_s) begin
                        sahip_q <= kazanan_s;
                        durum_q <= ISTEK;
                    end else begin
                        durum_q <= BOSTA;
                    end
                end
                ISTEK: begin
                    if (istek_el_sikisma_s) begin
                        durum_q <= sahip_yaz_s ? BOSTA : YANIT;
                    end else begin
                        durum_q <= ISTEK;
                    end
                end
                YANIT: begin
                    if (yanit_el_sikisma_s) begin
                        durum_q <= BOSTA;
                    end else begin
                        durum_q <= YANIT;
                    end
                end
                default: begin
                    durum_q <= BOSTA;
                    sahip_q <= '0;
                end
            endcase
        end
    end

    // Port and requester outputs: owner pass-through in ISTEK/YANIT, all zero in BOSTA.
    always_comb begin
        ist_hazir_o          = '0;
        yanit_gecerli_o      = '0;
        yanit_veri_o         = '0;
        port_istek_gecerli_o = LOW;
        port_istek_yaz_o     = LOW;
        port_istek_adres_o   = '0;
        port_istek_veri_o    = '0;
        port_istek_maske_o   = '0;
        port_veri_hazir_o    = LOW;
        case (durum_q)
            ISTEK: begin
                port_istek_gecerli_o = sahip_gecerli_s;
                port_istek_yaz_o     = sahip_yaz_s;
                port_istek_adres_o   = sahip_adres_s;
                port_istek_veri_o    = sahip_veri_s;
                port_istek_maske_o   = sahip_maske_s;
                for (int i = 0; i < N; i++) begin
                    ist_hazir_o[i] = (sahip_q == IW'(i)) & port_istek_hazir_i;
                end
            end
            YANIT: begin
                port_veri_hazir_o = sahip_yanit_hazir_s;
                yanit_veri_o      = port_veri_i;
                for (int i = 0; i < N; i++) begin
                    yanit_gecerli_o[i] = (sahip_q == IW'(i)) & port_veri_gecerli_i;
                end
            end
            BOSTA: begin
                ist_hazir_o = '0;
            end
            default: begin
                ist_hazir_o = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_l1_port_hakemi.sv
// Self-checking bench for l1_port_hakemi (N=2). Directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_l1_port_hakemi;

    localparam int N  = 2;
    localparam int AB = 32;
    localparam int VB = 32;
    localparam int MB = 4;
    localparam int W  = N + N + VB + 1 + 1 + AB + VB + MB + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N-1:0]    gec, yaz, ist_hazir, yanit_gecerli, yh;
    logic [N*AB-1:0] adr;
    logic [N*VB-1:0] veri;
    logic [N*MB-1:0] maske;
    logic [VB-1:0]   yanit_veri;
    logic            pig, piy, phz, pvg, pvh;
    logic [AB-1:0]   pia;
    logic [VB-1:0]   piv, pv;
    logic [MB-1:0]   pim;

    int n_cmp = 0;
    int n_err = 0;
    int ptr   = 0;

    l1_port_hakemi #(
        .ISTEKCI_SAYISI(N), .ADRES_BIT(AB), .VERI_BIT(VB), .VERI_BYTE(MB)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .ist_gecerli_i(gec), .ist_yaz_i(yaz), .ist_adres_i(adr),
        .ist_veri_i(veri), .ist_maske_i(maske), .ist_hazir_o(ist_hazir),
        .yanit_veri_o(yanit_veri), .yanit_gecerli_o(yanit_gecerli), .yanit_hazir_i(yh),
        .port_istek_gecerli_o(pig), .port_istek_yaz_o(piy), .port_istek_adres_o(pia),
        .port_istek_veri_o(piv), .port_istek_maske_o(pim), .port_istek_hazir_i(phz),
        .port_veri_i(pv), .port_veri_gecerli_i(pvg), .port_veri_hazir_o(pvh)
    );

    function automatic logic [W-1:0] paket(input logic [N-1:0] hz, input logic [N-1:0] yg,
                                           input logic [VB-1:0] yv, input logic g, input logic y,
                                           input logic [AB-1:0] a, input logic [VB-1:0] v,
                                           input logic [MB-1:0] m, input logic vh);
        return {hz, yg, yv, g, y, a, v, m, vh};
    endfunction

    function automatic logic [W-1:0] gozlem();
        return paket(ist_hazir, yanit_gecerli, yanit_veri, pig, piy, pia, piv, pim, pvh);
    endfunction

    // Expected outputs while requester o is in its request phase.
    function automatic logic [W-1:0] istek_beklenen(input int o, input logic hz);
        logic [N-1:0] bir;
        bir = 1;
        return paket(hz ? (bir << o) : '0, '0, '0, gec[o], yaz[o],
                     adr[o*AB +: AB], veri[o*VB +: VB], maske[o*MB +: MB], 1'b0);
    endfunction

    // Expected outputs while requester o waits for read data.
    function automatic logic [W-1:0] yanit_beklenen(input int o);
        logic [N-1:0] bir;
        bir = 1;
        return paket('0, pvg ? (bir << o) : '0, pv, 1'b0, 1'b0, '0, '0, '0, yh[o]);
    endfunction

    // Winner from the arbitration rule: scan upward from the pointer with wrap.
    function automatic int sec(input logic [N-1:0] req, input int p);
`ifdef L1_HAKEM_SABIT_ONCELIK_EN
        for (int i = 0; i < N; i++) if (req[i]) return i;
        return 0;
`else
        for (int off = 0; off < N; off++) begin
            int idx = (p + off) % N;
            if (req[idx]) return idx;
        end
        return 0;
`endif
    endfunction

    task automatic set_req(input int k, input logic w, input logic [AB-1:0] a,
                           input logic [VB-1:0] v, input logic [MB-1:0] m);
        gec[k] = 1'b1;
        yaz[k] = w;
        adr[k*AB +: AB]  = a;
        veri[k*VB +: VB] = v;
        maske[k*MB +: MB] = m;
    endtask

    task automatic reset_dut();
        rst = 1'b1; gec = '0; yaz = '0; adr = '0; veri = '0; maske = '0;
        yh = '0; phz = 1'b0; pv = '0; pvg = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ptr = 0;
    endtask

    task automatic test_reset();
        logic [W-1:0] exp_v;
        exp_v = '0;
        rst = 1'b1; gec = 2'b11; yaz = 2'b01; adr = {32'h1111_0000, 32'h2222_0000};
        veri = {32'hCAFE_0001, 32'hCAFE_0002}; maske = 8'hFF;
        yh = 2'b11; phz = 1'b1; pv = 32'h5555_AAAA; pvg = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if (gozlem() !== exp_v) begin
            n_err++; $display("FAIL reset_hold: got %h expected %h", gozlem(), exp_v);
        end
        rst = 1'b0; gec = '0;
        @(negedge clk); #1;
        n_cmp++;
        if (gozlem() !== exp_v) begin
            n_err++; $display("FAIL reset_idle: got %h expected %h", gozlem(), exp_v);
        end
    endtask

    task automatic test_single_write();
        logic [W-1:0] exp_v;
        reset_dut();
        set_req(0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
        #1; exp_v = '0; n_cmp++;
        if (gozlem() !== exp_v) begin
            n_err++; $display("FAIL write_arb: got %h expected %h", gozlem(), exp_v);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            phz = (c == 2);
            #1;
            exp_v = paket((c == 2) ? 2'b01 : 2'b00, '0, '0, 1'b1, 1'b1,
                          32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 1'b0);
            n_cmp++;
            if (gozlem() !== exp_v) begin
                n_err++; $display("FAIL write_istek c=%0d: got %h expected %h", c, gozlem(), exp_v);
            end
        end
        @(negedge clk);
        phz = 1'b0; gec = '0;
        #1; exp_v = '0; n_cmp++;
        if (gozlem() !== exp_v) begin
            n_err++; $display("FAIL write_done: got %h expected %h", gozlem(), exp_v);
        end
    endtask

    task automatic test_single_read();
        logic [W-1:0] exp_v;
        reset_dut();
        yh = 2'b11;
        set_req(1, 1'b0, 32'h0000_0200, 32'h0BAD_F00D, 4'h6);
        @(negedge clk);
        phz = 1'b1;
        #1;
        exp_v = paket(2'b10, '0, '0, 1'b1, 1'b0, 32'h0000_0200, 32'h0BAD_F00D, 4'h6, 1'b0);
        n_cmp++;
        if (gozlem() !== exp_v) begin
            n_err++; $display("FAIL read_istek: got %h expected %h", gozlem(), exp_v);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            phz = 1'b0; gec = '0;
            pvg = (c == 3);
            pv  = (c == 3) ? 32'h1234_5678 : $urandom;
            #1;
            exp_v = paket('0, (c == 3) ? 2'b10 : 2'b00, pv, 1'b0, 1'b0, '0, '0, '0, 1'b1);
            n_cmp++;
            if (gozlem() !== exp_v) begin
                n_err++; $display("FAIL read_yanit c=%0d: got %h expected %h", c, gozlem(), exp_v);
            end
        end
        @(negedge clk);
        pvg = 1'b0;
        #1; exp_v = '0; n_cmp++;
        if (gozlem() !== exp_v) begin
            n_err++; $display("FAIL read_done: got %h expected %h", gozlem(), exp_v);
        end
    endtask

    task automatic test_contention();
        logic [W-1:0] exp_v;
        logic [N-1:0] sira [4];
        int g;
        int o;
`ifdef L1_HAKEM_SABIT_ONCELIK_EN
        sira[0] = 2'b01; sira[1] = 2'b01; sira[2] = 2'b01; sira[3] = 2'b01;
`else
        sira[0] = 2'b01; sira[1] = 2'b10; sira[2] = 2'b01; sira[3] = 2'b10;
`endif
        reset_dut();
        set_req(0, 1'b1, 32'h0000_1000, 32'hAAAA_0000, 4'hF);
        set_req(1, 1'b1, 32'h0000_2000, 32'hBBBB_1111, 4'h3);
        phz = 1'b1;
        g = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (c % 2 == 0) begin
                exp_v = '0;
            end else begin
                o = sec(gec, ptr);
                exp_v = istek_beklenen(o, 1'b1);
                ptr = (o + 1) % N;
                n_cmp++;
                if (ist_hazir !== sira[g]) begin
                    n_err++; $display("FAIL contention_order g=%0d: got %b expected %b", g, ist_hazir, sira[g]);
                end
                g++;
            end
            n_cmp++;
            if (gozlem() !== exp_v) begin
                n_err++; $display("FAIL contention c=%0d: got %h expected %h", c, gozlem(), exp_v);
            end
            @(negedge clk);
        end
        gec = '0; phz = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_v;
        reset_dut();
        set_req(1, 1'b0, 32'h0000_3000, 32'h0, 4'h0);
        @(negedge clk);
        phz = 1'b1;
        @(negedge clk);
        phz = 1'b0; gec[1] = 1'b0;
        set_req(0, 1'b1, 32'h0000_4000, 32'h7777_8888, 4'h9);
        pvg = 1'b1; pv = 32'hFEED_0001;
        for (int c = 0; c < 6; c++) begin
            yh = (c == 5) ? 2'b10 : 2'b00;
            #1;
            exp_v = paket('0, 2'b10, 32'hFEED_0001, 1'b0, 1'b0, '0, '0, '0, (c == 5));
            n_cmp++;
            if (gozlem() !== exp_v) begin
                n_err++; $display("FAIL backpressure c=%0d: got %h expected %h", c, gozlem(), exp_v);
            end
            @(negedge clk);
        end
        pvg = 1'b0; yh = '0;
        #1; exp_v = '0; n_cmp++;
        if (gozlem() !== exp_v) begin
            n_err++; $display("FAIL backpressure_bubble: got %h expected %h", gozlem(), exp_v);
        end
        @(negedge clk);
        #1;
        exp_v = paket('0, '0, '0, 1'b1, 1'b1, 32'h0000_4000, 32'h7777_8888, 4'h9, 1'b0);
        n_cmp++;
        if (gozlem() !== exp_v) begin
            n_err++; $display("FAIL backpressure_next: got %h expected %h", gozlem(), exp_v);
        end
        phz = 1'b1;
        @(negedge clk);
        gec = '0; phz = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        logic [W-1:0] exp_v;
        reset_dut();
        yh = 2'b01;
        set_req(0, 1'b0, 32'h0000_5000, 32'h0, 4'h0);
        @(negedge clk);
        phz = 1'b1;
        @(negedge clk);
        phz = 1'b0; gec = '0;
        #1;
        exp_v = paket('0, '0, pv, 1'b0, 1'b0, '0, '0, '0, 1'b1);
        n_cmp++;
        if (gozlem() !== exp_v) begin
            n_err++; $display("FAIL midread_yanit: got %h expected %h", gozlem(), exp_v);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; pvg = 1'b1; pv = 32'hABCD_EF01;
        for (int c = 0; c < 2; c++) begin
            #1; exp_v = '0; n_cmp++;
            if (gozlem() !== exp_v) begin
                n_err++; $display("FAIL midread_reset c=%0d: got %h expected %h", c, gozlem(), exp_v);
            end
            @(negedge clk);
        end
        pvg = 1'b0;
    endtask

    task automatic test_random();
        logic [W-1:0] exp_v;
        logic [N-1:0] dus;
        int faz;
        int o;
        reset_dut();
        faz = 0; o = 0; dus = '0;
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < N; k++) if (dus[k]) gec[k] = 1'b0;
            dus = '0;
            for (int k = 0; k < N; k++) begin
                if (!gec[k] && ($urandom_range(0, 2) == 0))
                    set_req(k, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
            end
            phz = 1'($urandom_range(0, 1));
            pvg = 1'($urandom_range(0, 1));
            pv  = $urandom;
            yh  = 2'($urandom_range(0, 3));
            #1;
            if (faz == 1)      exp_v = istek_beklenen(o, phz);
            else if (faz == 2) exp_v = yanit_beklenen(o);
            else               exp_v = '0;
            n_cmp++;
            if (gozlem() !== exp_v) begin
                n_err++; $display("FAIL random c=%0d faz=%0d: got %h expected %h", c, faz, gozlem(), exp_v);
            end
            case (faz)
                0: if (|gec) begin o = sec(gec, ptr); faz = 1; end
                1: if (gec[o] && phz) begin
                       dus[o] = 1'b1;
                       if (yaz[o]) begin faz = 0; ptr = (o + 1) % N; end
                       else faz = 2;
                   end
                2: if (pvg && yh[o]) begin faz = 0; ptr = (o + 1) % N; end
                default: faz = 0;
            endcase
            @(negedge clk);
        end
        gec = '0; phz = 1'b0; pvg = 1'b0;
    endtask

    initial begin
        rst = 1'b1; gec = '0; yaz = '0; adr = '0; veri = '0; maske = '0;
        yh = '0; phz = 1'b0; pv = '0; pvg = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_backpressure();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/l1_port_hakemi.md
Name: l1_port_hakemi

Overview:
- Arbitrates between ISTEKCI_SAYISI requesters (veri_yolu_birimi instances, page-table walker, debug port) for one L1 data-cache port (port_istek_* / port_veri_*).
- Grants one requester at a time and holds the grant for the whole transaction: request handshake, plus the response handshake for reads.
- Routes the L1 response back to the owning requester only.
- Sits between the memory-side requesters and the L1 denetleyici.

Parameters:
- ISTEKCI_SAYISI, 2: number of requesters (2..8).
- ADRES_BIT, 32: address width.
- VERI_BIT, 32: data width.
- VERI_BYTE, VERI_BIT/8: byte-mask width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- ist_gecerli_i  in  N  per-requester request valid.
- ist_yaz_i  in  N  1 = write, 0 = read.
- ist_adres_i  in  N*ADRES_BIT  flattened addresses; requester k occupies bits [k*ADRES_BIT +: ADRES_BIT].
- ist_veri_i  in  N*VERI_BIT  flattened write data.
- ist_maske_i  in  N*VERI_BYTE  flattened byte masks.
- ist_hazir_o  out  N  request accepted (one-hot or zero).
- yanit_veri_o  out  VERI_BIT  read data, broadcast to all requesters.
- yanit_gecerli_o  out  N  read data valid (one-hot or zero).
- yanit_hazir_i  in  N  requester ready for read data.
- port_istek_gecerli_o  out  1  to L1.
- port_istek_yaz_o  out  1  to L1.
- port_istek_adres_o  out  ADRES_BIT  to L1.
- port_istek_veri_o  out  VERI_BIT  to L1.
- port_istek_maske_o  out  VERI_BYTE  to L1.
- port_istek_hazir_i  in  1  from L1.
- port_veri_i  in  VERI_BIT  from L1.
- port_veri_gecerli_i  in  1  from L1.
- port_veri_hazir_o  out  1  to L1.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is synchronous, active-high on rst_i.
- Reset values:
  - state = BOSTA, sahip_r = 0, rr_isaretci_r = 0.
  - All outputs 0 while in BOSTA.
- States:
  - BOSTA: no port activity. If any ist_gecerli_i bit is set, the picker chooses winner w, sahip_r <= w, state -> ISTEK. There is no handshake in this cycle, so arbitration costs exactly one cycle.
  - ISTEK:
    - port_istek_* outputs = combinational mux of requester sahip_r's inputs.
    - port_istek_gecerli_o = ist_gecerli_i[sahip_r].
    - ist_hazir_o[sahip_r] = port_istek_hazir_i; all other ist_hazir_o bits are 0.
    - On handshake (gecerli & hazir): if write, state -> BOSTA and rr_isaretci_r <= sahip_r+1 (mod N); if read, state -> YANIT.
  - YANIT:
    - port_veri_hazir_o = yanit_hazir_i[sahip_r].
    - yanit_gecerli_o[sahip_r] = port_veri_gecerli_i; yanit_veri_o = port_veri_i.
    - On handshake: state -> BOSTA and rr_isaretci_r updated as for writes.
- Round-robin: search starts at rr_isaretci_r and takes the first set ist_gecerli_i bit in increasing index order, wrapping at N-1 -> 0.
- Requester rule: ist_* fields must be held stable while ist_gecerli_i is high until ist_hazir_o. If the owner drops gecerli in ISTEK, port_istek_gecerli_o drops with it, the grant is kept, and there is no timeout.
- Non-owner requests are ignored until the block returns to BOSTA. No request is lost: requesters keep gecerli asserted.
- Transaction completion and a new request in the same cycle: the new request is arbitrated in the following BOSTA cycle. Back-to-back transactions therefore have a 1-cycle bubble.
- port_veri_gecerli_i or port_istek_hazir_i arriving in BOSTA is ignored and nothing is forwarded.
- Reset mid-transaction: immediate return to BOSTA and the transaction is abandoned. The L1 shares the same reset.
- Latency:
  - Write: request to accept is 1 cycle plus the L1 hazir delay.
  - Read: completion is 1 cycle plus the L1 request delay plus the L1 response delay.

Optional Feature:
- Macro: L1_HAKEM_SABIT_ONCELIK_EN.
- Defined: fixed priority, lowest index wins, rr_isaretci_r is not instantiated, and starvation of high indices is accepted.
- Undefined: round-robin as specified above.

Decomposition:
- sabitler.vh: ADRES_BIT, VERI_BIT, VERI_BYTE, HIGH/LOW.
- Local to the module: state localparams BOSTA=0, ISTEK=1, YANIT=2 (2-bit).
- One sub-module, hakem_oncelik_secici (combinational): inputs are the request vector and the pointer; outputs are the winner index and an any-valid flag. It contains the fixed/round-robin ifdef.

Test Plan:
- Single write, N=2: req0 writes adres 0x100, veri 0xDEADBEEF, maske 0xF, hazir 2 cycles later -> port_istek_* shows those values from the cycle after gecerli. ist_hazir_o=2'b01 for exactly 1 cycle, then BOSTA.
- Single read: req1 reads 0x200, L1 returns 0x12345678 with 3-cycle delay -> yanit_gecerli_o=2'b10 and yanit_veri_o=0x12345678. yanit_gecerli_o[0] stays 0 throughout.
- Contention, round-robin: both requesters assert writes continuously for 4 transactions -> grant order 0,1,0,1 with a 1-cycle BOSTA gap between transactions.
- Contention with L1_HAKEM_SABIT_ONCELIK_EN defined: same stimulus -> req0 is granted every time and req1 is never granted while req0 stays valid.
- Response backpressure: read owner holds yanit_hazir_i=0 for 5 cycles -> port_veri_hazir_o=0, state holds YANIT, and a pending req0 is not granted until the response handshake.
- Reset mid-read: rst_i asserted for 1 cycle in YANIT -> next cycle in BOSTA, all outputs 0, and a following port_veri_gecerli_i is not forwarded.
